// File: rtl/regfile_pkg.sv
// regfile_pkg: definitions shared by the register file, the issue logic and
// the write-port controller.
//   REGFILE_D_WIDTH    - default register data width
//   REGFILE_ADDR_WIDTH - default register address width
//   wb_entry_t         - one pending write-back (destination + data)
package regfile_pkg;

    localparam int REGFILE_D_WIDTH    = 32;
    localparam int REGFILE_ADDR_WIDTH = 6;

    typedef struct packed {
        logic [REGFILE_ADDR_WIDTH-1:0] addr;
        logic [REGFILE_D_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: write-back FIFO for long-latency results.
// Every slot is visible so the forwarding logic can search all of them.
// Ports:
//   clk, rst_n            - clock, async active-low reset (pointers only)
//   push, push_addr/data  - enqueue (caller guarantees not full)
//   pop                   - dequeue head (caller guarantees not empty)
//   head_addr/head_data   - oldest entry
//   full, empty, count    - occupancy
//   ent_addr/ent_data     - raw slot contents
//   ent_vld               - per-slot occupied flag
//   rd_idx                - slot index of the oldest entry (age origin)
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
    parameter int D_WIDTH    = REGFILE_D_WIDTH,
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic [ADDR_WIDTH-1:0]                push_addr,
    input  logic [D_WIDTH-1:0]                   push_data,
    input  logic                                 pop,
    output logic [ADDR_WIDTH-1:0]                head_addr,
    output logic [D_WIDTH-1:0]                   head_data,
    output logic                                 full,
    output logic                                 empty,
    output logic [PW:0]                          count,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]     ent_addr,
    output logic [DEPTH-1:0][D_WIDTH-1:0]        ent_data,
    output logic [DEPTH-1:0]                     ent_vld,
    output logic [PW-1:0]                        rd_idx
);

    // Extra MSB on each pointer separates full from empty.
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; stale slots are masked by ent_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr[PW-1:0]] <= push_addr;
            ent_data[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign rd_idx    = rd_ptr[PW-1:0];
    assign head_addr = ent_addr[rd_idx];
    assign head_data = ent_data[rd_idx];

    // A slot is occupied when its distance from the head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [PW-1:0] off;
        assign off        = PW'(i) - rd_idx;
        assign ent_vld[i] = ({1'b0, off} < count);
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: drives the register file's single write port.
// Merges single-cycle ALU results with buffered long-latency results,
// bounds FIFO starvation, and forwards pending / in-flight writes.
// Ports:
//   clk, rst_n                          - clock, async active-low reset
//   alu_valid/alu_waddr/alu_wdata       - ALU result (no backpressure)
//   lu_valid/lu_ready/lu_waddr/lu_wdata - long-latency result handshake
//   we/waddr/wdata                      - registered register-file write
//   fwd_raddr1/2, fwd_hit1/2, fwd_data1/2 - forwarding lookup
//   alu_stall                           - upstream must hold off the ALU
//   fifo_count                          - buffered entries
//   proto_err                           - sticky: ALU result while stalled
module regfile_wr_ctrl
    import regfile_pkg::*;
#(
    parameter int D_WIDTH      = REGFILE_D_WIDTH,
    parameter int ADDR_WIDTH   = REGFILE_ADDR_WIDTH,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [ADDR_WIDTH-1:0]     alu_waddr,
    input  logic [D_WIDTH-1:0]        alu_wdata,
    input  logic                      lu_valid,
    output logic                      lu_ready,
    input  logic [ADDR_WIDTH-1:0]     lu_waddr,
    input  logic [D_WIDTH-1:0]        lu_wdata,
    output logic                      we,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic [D_WIDTH-1:0]        wdata,
    input  logic [ADDR_WIDTH-1:0]     fwd_raddr1,
    input  logic [ADDR_WIDTH-1:0]     fwd_raddr2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [D_WIDTH-1:0]        fwd_data1,
    output logic [D_WIDTH-1:0]        fwd_data2,
    output logic                      alu_stall,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                                 fifo_full, fifo_empty;
    logic [ADDR_WIDTH-1:0]                head_addr;
    logic [D_WIDTH-1:0]                   head_data;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0]     ent_addr;
    logic [DEPTH-1:0][D_WIDTH-1:0]        ent_data;
    logic [DEPTH-1:0]                     ent_vld;
    logic [PW-1:0]                        rd_idx;
    logic [SW-1:0]                        starve_cnt;

    // r0 writes are architecturally void; an ALU result during stall is dropped.
    logic alu_req, alu_ok, fifo_ne, sel_fifo, sel_alu, push;
    assign alu_req  = alu_valid && (alu_waddr != '0);
    assign alu_ok   = alu_req && !alu_stall;
    assign fifo_ne  = !fifo_empty;
    assign sel_fifo = fifo_ne && (alu_stall || !alu_ok);
    assign sel_alu  = alu_ok && !sel_fifo;
    // No pass-through: a full FIFO refuses even if the head leaves this cycle.
    assign lu_ready = !fifo_full;
    assign push     = lu_valid && lu_ready && (lu_waddr != '0);

    wb_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .D_WIDTH(D_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (lu_waddr),
        .push_data (lu_wdata),
        .pop       (sel_fifo),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_vld   (ent_vld),
        .rd_idx    (rd_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (sel_fifo) begin
                we    <= 1'b1;
                waddr <= head_addr;
                wdata <= head_data;
            end else if (sel_alu) begin
                we    <= 1'b1;
                waddr <= alu_waddr;
                wdata <= alu_wdata;
            end else begin
                we    <= 1'b0;
            end

            // Counter saturates; stall follows one cycle after the limit is
            // reached, so the head loses at most STARVE_LIMIT+1 cycles.
            if (!fifo_ne || sel_fifo)
                starve_cnt <= '0;
            else if (sel_alu && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;

            if (sel_fifo)
                alu_stall <= 1'b0;
            else if (fifo_ne && starve_cnt == SW'(STARVE_LIMIT))
                alu_stall <= 1'b1;

            if (alu_req && alu_stall)
                proto_err <= 1'b1;
        end
    end

    // Forwarding: output register first, then FIFO oldest to newest, so the
    // youngest match overwrites older ones.
    logic [1:0][ADDR_WIDTH-1:0] fwd_raddr;
    logic [1:0]                 fwd_hit;
    logic [1:0][D_WIDTH-1:0]    fwd_data;
    assign fwd_raddr = {fwd_raddr2, fwd_raddr1};

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic               hit;
        logic [D_WIDTH-1:0] data;
        logic [PW-1:0]      idx;
        always_comb begin
            hit  = 1'b0;
            data = '0;
            idx  = '0;
            if (we && waddr == fwd_raddr[p]) begin
                hit  = 1'b1;
                data = wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_idx + PW'(i);
                if (ent_vld[idx] && ent_addr[idx] == fwd_raddr[p]) begin
                    hit  = 1'b1;
                    data = ent_data[idx];
                end
            end
            if (fwd_raddr[p] == '0) begin
                hit  = 1'b0;
                data = '0;
            end
        end
        assign fwd_hit[p]  = hit;
        assign fwd_data[p] = data;
    end

    assign fwd_hit1  = fwd_hit[0];
    assign fwd_hit2  = fwd_hit[1];
    assign fwd_data1 = fwd_data[0];
    assign fwd_data2 = fwd_data[1];

endmodule
